aes_frame_ctrl: RTL and testbench

- Sequences the shared AES core between the RS-232 receive path and the RS-232 transmit path.
- Collects two 64-bit received packets into one 128-bit block and launches the AES core.
- Waits for AES completion, with a watchdog.
- Returns the result to the transmitter as a 0x02 header byte followed by 16 data bytes, one byte per transmitter handshake.

---
 rtl/aes_link_pkg.sv | 22 ++
 rtl/aes_watchdog.sv | 25 ++
 rtl/aes_frame_ctrl.sv | 148 ++++++++++++++
 tb/tb_aes_frame_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_link_pkg.sv
// Shared definitions for the RS-232 <-> AES frame controller.
// State encoding, frame header and block geometry.
package aes_link_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HALF     = 3'd1,
    LAUNCH   = 3'd2,
    WAIT_AES = 3'd3,
    TX_HDR   = 3'd4,
    TX_GAP   = 3'd5,
    TX_WAIT  = 3'd6,
    TX_DATA  = 3'd7
  } state_t;

  localparam logic [7:0] HDR_BYTE = 8'h02;

  localparam int BLOCK_W         = 128;
  localparam int PKT_W           = 64;
  localparam int BYTES_PER_BLOCK = 16;

endpackage

// File: rtl/aes_watchdog.sv
// Watchdog counter for the AES core round trip.
// Cleared at launch, counts while enabled, flags the last allowed cycle.
module aes_watchdog #(
  parameter int AES_TIMEOUT = 4096,
  parameter int CNT_W       = 13
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (en)
      cnt <= cnt + 1'b1;
  end

  assign expire = (cnt == CNT_W'(AES_TIMEOUT - 1));

endmodule

// File: rtl/aes_frame_ctrl.sv
// Sequences the shared AES core between the UART receive and
// transmit paths: two packets in, header plus 16 result bytes out.
module aes_frame_ctrl
  import aes_link_pkg::*;
#(
  parameter int         AES_TIMEOUT = 4096,
  parameter logic [7:0] HDR_BYTE    = aes_link_pkg::HDR_BYTE,
  parameter int         CNT_W       = 13
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_valid,
  input  logic [PKT_W-1:0]   rx_data,
  output logic               rx_ready,
  output logic               aes_start,
  output logic [BLOCK_W-1:0] aes_din,
  input  logic               aes_done,
  input  logic [BLOCK_W-1:0] aes_dout,
  output logic               tx_start,
  output logic [7:0]         tx_byte,
  input  logic               tx_busy,
  output logic               busy,
  output logic               err_timeout
);

  state_t state, state_nx;

  logic [BLOCK_W-1:0] din_q;
  logic [BLOCK_W-1:0] res_q;
  logic [3:0]         byte_idx;
  logic               last_q;
  logic [7:0]         byte_q;
  logic               wd_clr;
  logic               wd_en;
  logic               wd_exp;

  aes_watchdog #(
    .AES_TIMEOUT(AES_TIMEOUT),
    .CNT_W      (CNT_W)
  ) u_wd (
    .clk   (clk),
    .rst   (rst),
    .clr   (wd_clr),
    .en    (wd_en),
    .expire(wd_exp)
  );

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    rx_ready    = 1'b0;
    aes_start   = 1'b0;
    tx_start    = 1'b0;
    err_timeout = 1'b0;
    wd_clr      = 1'b0;
    wd_en       = 1'b0;
    unique case (state)
      IDLE: begin
        rx_ready = 1'b1;
        if (rx_valid)
          state_nx = HALF;
      end
      HALF: begin
        rx_ready = 1'b1;
        if (rx_valid)
          state_nx = LAUNCH;
      end
      LAUNCH: begin
        aes_start = 1'b1;
        wd_clr    = 1'b1;
        state_nx  = WAIT_AES;
      end
      WAIT_AES: begin
        // a completion on the expiry cycle still counts as success
        if (aes_done) begin
          state_nx = TX_HDR;
        end else begin
          wd_en = 1'b1;
          if (wd_exp) begin
            err_timeout = 1'b1;
            state_nx    = IDLE;
          end
        end
      end
      TX_HDR: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_nx = TX_GAP;
        end
      end
      TX_GAP: begin
        state_nx = TX_WAIT;
      end
      TX_WAIT: begin
        if (!tx_busy)
          state_nx = last_q ? IDLE : TX_DATA;
      end
      TX_DATA: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_nx = TX_GAP;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      din_q    <= '0;
      res_q    <= '0;
      byte_idx <= '0;
      last_q   <= 1'b0;
      byte_q   <= '0;
    end else begin
      if (state == IDLE && rx_valid)
        din_q[BLOCK_W-1:PKT_W] <= rx_data;
      if (state == HALF && rx_valid)
        din_q[PKT_W-1:0] <= rx_data;
      if (state == WAIT_AES && aes_done) begin
        res_q    <= aes_dout;
        byte_idx <= '0;
        last_q   <= 1'b0;
        byte_q   <= HDR_BYTE;
      end
      // result shifts out MSB byte first
      if (state == TX_WAIT && !tx_busy && !last_q) begin
        byte_q <= res_q[BLOCK_W-1 -: 8];
        res_q  <= res_q << 8;
      end
      if (state == TX_DATA && !tx_busy) begin
        byte_idx <= byte_idx + 1'b1;
        last_q   <= (byte_idx == 4'(BYTES_PER_BLOCK - 1));
      end
    end
  end

  assign aes_din = din_q;
  assign tx_byte = byte_q;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_aes_frame_ctrl.sv
// Scoreboard bench for aes_frame_ctrl with AES and UART TX models.
// Stimulus queues expectations; a negedge monitor pops and compares.
module tb_aes_frame_ctrl;

  localparam int TO = 40;
  localparam int CW = 6;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rx_valid = 1'b0;
  logic [63:0]  rx_data = '0;
  logic         rx_ready;
  logic         aes_start;
  logic [127:0] aes_din;
  logic         aes_done;
  logic [127:0] aes_dout;
  logic         tx_start;
  logic [7:0]   tx_byte;
  logic         tx_busy;
  logic         busy;
  logic         err_timeout;

  always #5 clk = ~clk;

  aes_frame_ctrl #(
    .AES_TIMEOUT(TO),
    .HDR_BYTE   (8'h02),
    .CNT_W      (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .aes_start  (aes_start),
    .aes_din    (aes_din),
    .aes_done   (aes_done),
    .aes_dout   (aes_dout),
    .tx_start   (tx_start),
    .tx_byte    (tx_byte),
    .tx_busy    (tx_busy),
    .busy       (busy),
    .err_timeout(err_timeout)
  );

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  int tx_seen = 0;
  int err_seen = 0;
  int done_cyc = 0;
  int aes_delay = 0;
  int acnt = 0;
  int txc = 0;
  logic s_aes_start = 1'b0;
  logic s_tx_start = 1'b0;
  logic [127:0] aes_res = '0;
  logic [127:0] cur_din = '0;
  logic [7:0]   e_byte;
  logic [127:0] exp_din[$];
  logic [7:0]   exp_byte[$];

  assign aes_done = (acnt == 1);
  assign aes_dout = aes_res;
  assign tx_busy  = (txc != 0);

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // AES model answers aes_delay cycles after launch; 0 means never
  always @(posedge clk) begin
    if (s_aes_start && aes_delay > 0)
      acnt <= aes_delay;
    else if (acnt != 0)
      acnt <= acnt - 1;
    if (s_tx_start)
      txc <= 10;
    else if (txc != 0)
      txc <= txc - 1;
  end

  always @(negedge clk) begin
    s_aes_start = aes_start;
    s_tx_start  = tx_start;
    if (err_timeout)
      err_seen++;
    if (aes_start) begin
      if (exp_din.size() == 0) begin
        chk("unexpected_aes_start", 1, 0);
      end else begin
        cur_din = exp_din.pop_front();
        chk("aes_din", aes_din, cur_din);
      end
    end
    if (aes_done && busy) begin
      chk("aes_din_hold", aes_din, cur_din);
      done_cyc = cyc;
    end
    if (tx_start) begin
      tx_seen++;
      chk("tx_while_busy", tx_busy, 0);
      if (exp_byte.size() == 0) begin
        chk("unexpected_tx", 1, 0);
      end else begin
        e_byte = exp_byte.pop_front();
        chk("tx_byte", tx_byte, e_byte);
        if (exp_byte.size() == 16)
          chk("hdr_latency", cyc, done_cyc + 1);
      end
    end
  end

  task automatic check_reset_outs();
    chk("rst_rx_ready", rx_ready, 1);
    chk("rst_aes_start", aes_start, 0);
    chk("rst_aes_din", aes_din, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_byte", tx_byte, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_timeout, 0);
  endtask

  task automatic send_pkt(input logic [63:0] d);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = d;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic exchange(input logic [127:0] blk,
                          input logic [127:0] res, input int delay);
    aes_res   = res;
    aes_delay = delay;
    exp_din.push_back(blk);
    if (delay > 0) begin
      exp_byte.push_back(8'h02);
      for (int i = 15; i >= 0; i--)
        exp_byte.push_back(res[8*i +: 8]);
    end
    send_pkt(blk[127:64]);
    send_pkt(blk[63:0]);
    chk("start_latency", aes_start, 1);
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (!busy && exp_byte.size() == 0)
        break;
    end
    chk("tx_drained", exp_byte.size(), 0);
    chk("busy_low", busy, 0);
  endtask

  task automatic settle();
    repeat (15) @(negedge clk);
  endtask

  int e0;
  int base;

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outs();
    rst = 1'b0;

    exchange(128'h00112233445566778899aabbccddeeff,
             128'h000102030405060708090a0b0c0d0e0f, 5);
    wait_idle(400);
    chk("no_err_normal", err_seen, 0);
    settle();

    e0 = err_seen;
    exchange(128'hdeadbeef01234567cafef00d89abcdef, '0, 0);
    wait_idle(TO + 20);
    chk("timeout_err", err_seen, e0 + 1);
    chk("timeout_rx_ready", rx_ready, 1);
    chk("timeout_din_kept", aes_din,
        128'hdeadbeef01234567cafef00d89abcdef);
    exchange(128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0,
             128'hffeeddccbbaa99887766554433221100, 5);
    wait_idle(400);
    settle();

    e0 = err_seen;
    exchange(128'h11111111222222223333333344444444,
             128'ha5a5a5a55a5a5a5a0123456789abcdef, TO);
    wait_idle(TO + 400);
    chk("coincident_no_err", err_seen, e0);
    settle();

    base = tx_seen;
    exchange(128'h0123456789abcdeffedcba9876543210,
             128'h13579bdf02468ace13579bdf02468ace, 5);
    send_pkt(64'hbadbadbadbadbad0);
    for (int i = 0; i < 100 && tx_seen < base + 2; i++)
      @(negedge clk);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 64'h5555aaaa5555aaaa;
    repeat (30) @(negedge clk);
    rx_valid = 1'b0;
    chk("ignored_rx_din", aes_din,
        128'h0123456789abcdeffedcba9876543210);
    wait_idle(400);
    settle();

    base = tx_seen;
    exchange(128'h2468ace013579bdf2468ace013579bdf,
             128'h00ff11ee22dd33cc44bb55aa66997788, 5);
    for (int i = 0; i < 200 && tx_seen < base + 5; i++)
      @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    exp_byte.delete();
    @(negedge clk);
    check_reset_outs();
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("no_tx_after_rst", tx_seen, base + 5);
    chk("idle_after_rst", busy, 0);

    exchange(128'hfedcba98765432100123456789abcdef,
             128'h0102030405060708090a0b0c0d0e0f10, 5);
    wait_idle(400);
    chk("din_all_used", exp_din.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
